// File: rtl/adder_operand_fifo.sv
// First-word-fall-through FIFO of operand pairs feeding the ripple adder.
// Every output is a flop, so the adder inputs and both handshakes are free of input-to-output paths.
module adder_operand_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [CNTW-1:0]  Count,
    output logic             Overflow
);

    localparam int             PTRW     = $clog2(DEPTH);
    localparam logic [PTRW-1:0] PTR_ONE  = PTRW'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);

    logic [WIDTH-1:0] mem_a_r [DEPTH];
    logic [WIDTH-1:0] mem_b_r [DEPTH];
    logic [PTRW-1:0]  wr_ptr_r;
    logic [PTRW-1:0]  rd_ptr_r;
    logic [CNTW-1:0]  count_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_a_r;
    logic [WIDTH-1:0] out_b_r;
    logic             overflow_r;

    logic             push_s;
    logic             pop_s;
    logic [PTRW-1:0]  wr_ptr_nxt_s;
    logic [PTRW-1:0]  rd_ptr_nxt_s;
    logic [CNTW-1:0]  count_nxt_s;
    logic [WIDTH-1:0] head_a_nxt_s;
    logic [WIDTH-1:0] head_b_nxt_s;

    assign push_s = InValid & in_ready_r;
    assign pop_s  = out_valid_r & OutReady;

    // Pointer and occupancy update for this edge's handshakes.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        case ({push_s, pop_s})
            2'b10: begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                count_nxt_s  = count_r + CNT_ONE;
            end
            2'b01: begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
                count_nxt_s  = count_r - CNT_ONE;
            end
            2'b11: begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end
            default: begin
                wr_ptr_nxt_s = wr_ptr_r;
                rd_ptr_nxt_s = rd_ptr_r;
                count_nxt_s  = count_r;
            end
        endcase
    end

    // Next head entry; the slot being written this edge becomes the head when the FIFO
    // held zero entries (push only) or one entry (push with pop), so forward it from the input.
    always_comb begin
        head_a_nxt_s = {WIDTH{1'b0}};
        head_b_nxt_s = {WIDTH{1'b0}};
        if (count_nxt_s == CNT_ZERO) begin
            head_a_nxt_s = {WIDTH{1'b0}};
            head_b_nxt_s = {WIDTH{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_a_nxt_s = InA;
            head_b_nxt_s = InB;
        end else begin
            head_a_nxt_s = mem_a_r[rd_ptr_nxt_s];
            head_b_nxt_s = mem_b_r[rd_ptr_nxt_s];
        end
    end

    // Operand storage; contents are don't-care after reset so no reset term.
    always_ff @(posedge Clk) begin
        if (push_s && !Rst) begin
            mem_a_r[wr_ptr_r] <= InA;
            mem_b_r[wr_ptr_r] <= InB;
        end
    end

    // Control state and registered outputs; reset wins over any handshake.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr_r    <= {PTRW{1'b0}};
            rd_ptr_r    <= {PTRW{1'b0}};
            count_r     <= CNT_ZERO;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_a_r     <= {WIDTH{1'b0}};
            out_b_r     <= {WIDTH{1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            in_ready_r  <= (count_nxt_s != CNT_FULL);
            out_valid_r <= (count_nxt_s != CNT_ZERO);
            out_a_r     <= head_a_nxt_s;
            out_b_r     <= head_b_nxt_s;
            overflow_r  <= overflow_r | (InValid & ~in_ready_r);
        end
    end

    assign InReady  = in_ready_r;
    assign OutValid = out_valid_r;
    assign OutA     = out_a_r;
    assign OutB     = out_b_r;
    assign Count    = count_r;
    assign Overflow = overflow_r;

endmodule

// File: tb/tb_adder_operand_fifo.sv
// Scoreboard bench for adder_operand_fifo: a queue model predicts every output each cycle.
module tb_adder_operand_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CNTW  = $clog2(DEPTH + 1);

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [WIDTH-1:0] InA = 16'h0000;
    logic [WIDTH-1:0] InB = 16'h0000;
    logic             OutValid;
    logic             OutReady = 1'b0;
    logic [WIDTH-1:0] OutA;
    logic [WIDTH-1:0] OutB;
    logic [CNTW-1:0]  Count;
    logic             Overflow;

    int               n_vec  = 0;
    int               n_miss = 0;
    logic [31:0]      sb_q[$];
    logic             m_ovf = 1'b0;
    logic [15:0]      a_seq;

    adder_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Rst(Rst),
        .InValid(InValid), .InReady(InReady), .InA(InA), .InB(InB),
        .OutValid(OutValid), .OutReady(OutReady), .OutA(OutA), .OutB(OutB),
        .Count(Count), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, compare registered outputs with the model, then advance both.
    task automatic step(input logic rst, input logic iv, input logic [15:0] a,
                        input logic [15:0] b, input logic ordy, input logic do_chk);
        logic m_ready;
        logic m_valid;
        Rst = rst; InValid = iv; InA = a; InB = b; OutReady = ordy;
        m_ready = (sb_q.size() != DEPTH);
        m_valid = (sb_q.size() != 0);
        if (do_chk) begin
            chk("count",    32'(Count),    32'(sb_q.size()));
            chk("inready",  32'(InReady),  32'(m_ready));
            chk("outvalid", 32'(OutValid), 32'(m_valid));
            chk("outa",     32'(OutA),     m_valid ? 32'(sb_q[0][31:16]) : 32'h0);
            chk("outb",     32'(OutB),     m_valid ? 32'(sb_q[0][15:0])  : 32'h0);
            chk("overflow", 32'(Overflow), 32'(m_ovf));
        end
        if (rst) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (iv && !m_ready) m_ovf = 1'b1;
            if (m_valid && ordy) void'(sb_q.pop_front());
            if (iv && m_ready) sb_q.push_back({a, b});
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        // Reset with InValid held high: nothing may be stored.
        step(1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Single pass-through.
        step(1'b0, 1'b1, 16'h1234, 16'h0FFF, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Fill, overflow on the fifth push, then drain.
        for (int k = 1; k <= 5; k++)
            step(1'b0, 1'b1, 16'(k), 16'(16'hFFFF - 16'(k)), 1'b0, 1'b1);
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);

        // Steady push+pop at occupancy 2 across several pointer wraps.
        a_seq = 16'h0100;
        for (int k = 0; k < 2; k++) begin
            step(1'b0, 1'b1, a_seq, ~a_seq, 1'b0, 1'b1);
            a_seq++;
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, a_seq, ~a_seq, 1'b1, 1'b1);
            a_seq++;
        end
        for (int k = 0; k < 3; k++)
            step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);

        // Full plus pop from a clean overflow flag: push rejected, pop taken.
        step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b1, 16'(16'h0200 + 16'(k)), 16'(16'h0300 + 16'(k)), 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h0999, 16'h0888, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        // Reset mid-stream at occupancy 3 with a simultaneous push and pop.
        step(1'b1, 1'b1, 16'h7777, 16'h6666, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);

        // Random traffic against the same model.
        for (int k = 0; k < 200; k++)
            step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 1)), 1'b1);
        for (int k = 0; k < 5; k++)
            step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
